// File: rtl/nor_read_streamer.sv
// Wishbone burst reader for nor_bus: issues pipelined reads under a FIFO credit limit
// and streams returned words out. Optional running checksum via NOR_STREAM_CHECKSUM_EN.
module nor_read_streamer #(
  parameter int ADDRBITS   = 26,
  parameter int DATABITS   = 16,
  parameter int LENBITS    = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                cmd_start_i,
  input  logic [ADDRBITS-1:0] cmd_addr_i,
  input  logic [LENBITS-1:0]  cmd_len_i,
  output logic                cmd_busy_o,
  output logic                cmd_done_o,
  output logic                cmd_err_o,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  output logic                wb_we_o,
  output logic [ADDRBITS-1:0] wb_adr_o,
  output logic [DATABITS-1:0] wb_dat_o,
  input  logic                wb_ack_i,
  input  logic [DATABITS-1:0] wb_dat_i,
  input  logic                wb_stall_i,
  input  logic                wb_err_i,
`ifdef NOR_STREAM_CHECKSUM_EN
  output logic [DATABITS-1:0] sum_o,
`endif
  output logic                m_valid_o,
  output logic [DATABITS-1:0] m_data_o,
  input  logic                m_ready_i
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t              state;
  logic [1:0]          rst_sync;
  logic                rst;
  logic [LENBITS-1:0]  remaining;
  logic [CW-1:0]       outstanding;
  logic [CW-1:0]       count;
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [DATABITS-1:0] mem [FIFO_DEPTH];
  logic                credit_ok;
  logic                accept;
  logic                push;
  logic                pop;
  logic                bus_err;

  // Reset asserts immediately, releases two clocks after wb_rst_i falls.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) rst_sync <= 2'b11;
    else          rst_sync <= {rst_sync[0], 1'b0};
  end
  assign rst = rst_sync[1];

  assign credit_ok = ({1'b0, outstanding} + {1'b0, count}) < (CW+1)'(FIFO_DEPTH);
  assign wb_stb_o  = (state == ISSUE) && credit_ok;
  assign wb_cyc_o  = (state == ISSUE) || (state == DRAIN);
  assign wb_we_o   = 1'b0;
  assign wb_dat_o  = '0;
  assign cmd_busy_o = (state != IDLE);
  assign cmd_done_o = (state == DONE);
  assign accept    = wb_stb_o && !wb_stall_i;
  assign push      = wb_ack_i && (outstanding != '0);
  assign pop       = m_valid_o && m_ready_i;
  assign bus_err   = wb_err_i && wb_cyc_o;
  assign m_valid_o = (count != '0);
  assign m_data_o  = mem[rd_ptr];

  always_ff @(posedge wb_clk_i or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wb_adr_o    <= '0;
      remaining   <= '0;
      outstanding <= '0;
      cmd_err_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cmd_start_i) begin
          cmd_err_o <= 1'b0;
          if (cmd_len_i != '0) begin
            wb_adr_o  <= cmd_addr_i;
            remaining <= cmd_len_i;
            state     <= ISSUE;
          end else begin
            state <= DONE;
          end
        end
        ISSUE: if (bus_err) begin
          cmd_err_o <= 1'b1;
          state     <= DONE;
        end else if (accept) begin
          wb_adr_o  <= wb_adr_o + ADDRBITS'(1);
          remaining <= remaining - LENBITS'(1);
          if (remaining == LENBITS'(1)) state <= DRAIN;
        end
        DRAIN: if (bus_err) begin
          cmd_err_o <= 1'b1;
          state     <= DONE;
        end else if (outstanding == '0) begin
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
      // An error abandons every in-flight request; late acks then fall on outstanding==0.
      if (bus_err) outstanding <= '0;
      else         outstanding <= outstanding + CW'(accept) - CW'(push);
    end
  end

  always_ff @(posedge wb_clk_i or posedge rst) begin
    if (rst) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push) mem[wr_ptr] <= wb_dat_i;
  end

`ifdef NOR_STREAM_CHECKSUM_EN
  always_ff @(posedge wb_clk_i or posedge rst) begin
    if (rst)                                sum_o <= '0;
    else if (state == IDLE && cmd_start_i)  sum_o <= '0;
    else if (push)                          sum_o <= sum_o + wb_dat_i;
  end
`endif

endmodule

// File: tb/tb_nor_read_streamer.sv
// Directed + randomized bench for nor_read_streamer with an in-bench pipelined slave
// and a word-level reference model (address sequence, stream contents, credit bound).
module tb_nor_read_streamer;
  localparam int AB = 26, DB = 16, LB = 16, DEPTH = 16;

  logic          wb_clk_i = 0, wb_rst_i = 0, cmd_start_i = 0;
  logic [AB-1:0] cmd_addr_i = '0;
  logic [LB-1:0] cmd_len_i = '0;
  logic          cmd_busy_o, cmd_done_o, cmd_err_o, wb_cyc_o, wb_stb_o, wb_we_o;
  logic [AB-1:0] wb_adr_o;
  logic [DB-1:0] wb_dat_o, wb_dat_i = '0, m_data_o;
  logic          wb_ack_i = 0, wb_stall_i = 0, wb_err_i = 0, m_valid_o, m_ready_i = 0;
`ifdef NOR_STREAM_CHECKSUM_EN
  logic [DB-1:0] sum_o;
`endif

  nor_read_streamer #(.ADDRBITS(AB), .DATABITS(DB), .LENBITS(LB), .FIFO_DEPTH(DEPTH)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .cmd_start_i(cmd_start_i),
    .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i), .cmd_busy_o(cmd_busy_o),
    .cmd_done_o(cmd_done_o), .cmd_err_o(cmd_err_o), .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
    .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i), .wb_stall_i(wb_stall_i), .wb_err_i(wb_err_i),
`ifdef NOR_STREAM_CHECKSUM_EN
    .sum_o(sum_o),
`endif
    .m_valid_o(m_valid_o), .m_data_o(m_data_o), .m_ready_i(m_ready_i));

  always #5 wb_clk_i = ~wb_clk_i;

  int checks = 0, errors = 0;
  int cyc_n = 0, acc_n = 0, resp_n = 0, err_resp = 0, done_n = 0;
  int lat = 1, ready_pct = 100, stall_pct = 0, force_stall = 0, lvl = 0, max_occ = 0;
  bit cyc_seen = 0, fire_err = 0;
  logic [DB-1:0] salt = '0, exp_sum = '0;
  int unsigned pend_adr[$], exp_adr[$], acc_q[$];
  int pend_due[$];
  logic [DB-1:0] got_q[$], exp_q[$];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DB-1:0] dfun(int unsigned a);
    return a[15:0] ^ salt;
  endfunction

  // One bus cycle: entered and left at a falling edge. The slave answers in order,
  // one response per cycle, lat cycles after accept; cyc low flushes its queue.
  task automatic step();
    wb_ack_i = 0; wb_err_i = 0; wb_dat_i = '0; fire_err = 0;
    if (force_stall > 0) begin wb_stall_i = 1; force_stall--; end
    else wb_stall_i = ($urandom_range(99) < stall_pct);
    m_ready_i = ($urandom_range(99) < ready_pct);
    if (pend_adr.size() > 0 && pend_due[0] <= cyc_n) begin
      resp_n++;
      if (resp_n == err_resp) begin
        wb_err_i = 1; fire_err = 1;
        pend_adr.delete(); pend_due.delete();
      end else begin
        wb_ack_i = 1; wb_dat_i = dfun(pend_adr.pop_front());
        void'(pend_due.pop_front());
        lvl++;
      end
    end
    #1;
    if (wb_stb_o && !wb_stall_i) begin
      acc_q.push_back(wb_adr_o); pend_adr.push_back(wb_adr_o);
      pend_due.push_back(cyc_n + lat); acc_n++;
    end
    if (m_valid_o && m_ready_i) begin got_q.push_back(m_data_o); lvl--; end
    if (wb_cyc_o) cyc_seen = 1;
    if (pend_adr.size() + lvl > max_occ) max_occ = pend_adr.size() + lvl;
    @(posedge wb_clk_i); #1;
    if (cmd_done_o) done_n++;
    if (fire_err) chk("err_next_cycle", {wb_cyc_o, cmd_done_o, cmd_err_o}, 3'b011);
    @(negedge wb_clk_i);
    cyc_n++;
  endtask

  task automatic start_cmd(int unsigned addr, int len, logic [DB-1:0] s);
    int nexp;
    salt = s;
    nexp = (err_resp > 0 && err_resp - 1 < len) ? err_resp - 1 : len;
    exp_adr.delete(); acc_q.delete();
    for (int i = 0; i < len; i++) exp_adr.push_back((addr + i) % (1 << AB));
    exp_sum = '0;
    for (int i = 0; i < nexp; i++) begin
      exp_q.push_back(dfun(exp_adr[i]));
      exp_sum += dfun(exp_adr[i]);
    end
    done_n = 0; cyc_seen = 0; resp_n = 0; acc_n = 0; max_occ = 0;
    cmd_start_i = 1; cmd_addr_i = AB'(addr); cmd_len_i = LB'(len);
    step();
    cmd_start_i = 0; cmd_addr_i = '0; cmd_len_i = '0;
    chk("busy_after_start", cmd_busy_o, 1);
  endtask

  task automatic wait_done(int budget);
    int n = 0;
    while (done_n == 0 && n < budget) begin step(); n++; end
    chk("done_seen", done_n, 1);
    step();
    chk("done_single_pulse", {done_n[7:0], cmd_busy_o}, {8'd1, 1'b0});
  endtask

  task automatic drain_check(string tag, logic err_exp);
    int n = 0;
    bit same;
    ready_pct = 100;
    while (m_valid_o && n < 100) begin step(); n++; end
    same = (got_q.size() == exp_q.size());
    for (int i = 0; same && i < got_q.size(); i++) same = (got_q[i] === exp_q[i]);
    if (!same) $display("%s stream got=%p want=%p", tag, got_q, exp_q);
    chk({tag, "_stream"}, same, 1);
    same = (acc_q.size() <= exp_adr.size());
    if (err_exp == 0) same = same && (acc_q.size() == exp_adr.size());
    for (int i = 0; same && i < acc_q.size(); i++) same = (acc_q[i] == exp_adr[i]);
    chk({tag, "_addrs"}, same, 1);
    chk({tag, "_credit"}, max_occ <= DEPTH, 1);
    chk({tag, "_err"}, cmd_err_o, err_exp);
`ifdef NOR_STREAM_CHECKSUM_EN
    chk({tag, "_sum"}, sum_o, exp_sum);
`endif
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    #1 wb_rst_i = 1;
    repeat (3) @(negedge wb_clk_i);
    chk("rst_ctrl", {wb_cyc_o, wb_stb_o, cmd_busy_o, cmd_done_o, cmd_err_o, m_valid_o, wb_we_o}, 7'b0);
    chk("rst_adr", wb_adr_o, 0);
    wb_rst_i = 0;
    repeat (3) step();

    // basic: data = address, ack two cycles after accept
    lat = 2; stall_pct = 0; ready_pct = 100; err_resp = 0;
    start_cmd(32'h100, 4, 16'h0000);
    wait_done(50);
    chk("basic_first_word", exp_q.size() > 0 ? got_q[0] : 16'hxxxx, 16'h0100);
    drain_check("basic", 0);

    // back-pressure: consumer stalled
    lat = 1; ready_pct = 0;
    start_cmd(32'h2000, 40, 16'h5a5a);
    repeat (60) step();
    chk("bp_accepts", acc_n, DEPTH);
    chk("bp_stb_cyc", {wb_stb_o, wb_cyc_o}, 2'b01);
    ready_pct = 100;
    wait_done(300);
    drain_check("bp", 0);

    // stall window mid-burst
    lat = 2;
    start_cmd(32'h5000, 8, 16'h1234);
    for (int n = 0; acc_n < 3 && n < 20; n++) step();
    force_stall = 5;
    repeat (5) step();
    chk("stall_adr_hold", wb_adr_o, 26'h5003);
    chk("stall_no_accept", acc_n, 3);
    wait_done(50);
    drain_check("stall", 0);

    // address wrap, then zero-length
    start_cmd(32'h3FFFFFE, 3, 16'h00ff);
    wait_done(50);
    chk("wrap_third_adr", acc_q.size() == 3 ? acc_q[2] : 32'hffff_ffff, 0);
    drain_check("wrap", 0);
    start_cmd(32'h777, 0, 16'h0);
    wait_done(5);
    chk("zero_no_cyc", cyc_seen, 0);
    drain_check("zero", 0);

    // error on the 4th response
    lat = 1; err_resp = 4;
    start_cmd(32'h800, 10, 16'hbeef);
    wait_done(50);
    err_resp = 0;
    drain_check("err", 1);
    start_cmd(32'h880, 5, 16'h0f0f);
    wait_done(50);
    drain_check("after_err", 0);

    // async reset with 3 requests in flight and data buffered
    lat = 3; ready_pct = 0;
    start_cmd(32'h900, 10, 16'h4321);
    for (int n = 0; acc_n < 6 && n < 30; n++) step();
    chk("pre_rst_state", {wb_cyc_o, m_valid_o, 8'(pend_adr.size())}, {2'b11, 8'd3});
    wb_rst_i = 1; #1;
    chk("async_rst_drop", {wb_cyc_o, wb_stb_o, m_valid_o}, 3'b000);
    @(negedge wb_clk_i); @(negedge wb_clk_i);
    wb_rst_i = 0;
    pend_adr.delete(); pend_due.delete(); got_q.delete(); exp_q.delete(); lvl = 0;
    ready_pct = 100;
    repeat (3) step();
    chk("post_rst_adr", wb_adr_o, 0);
    start_cmd(32'hA00, 2, 16'h0000);
    wait_done(50);
    drain_check("post_rst", 0);

    // randomized commands
    stall_pct = 25;
    for (int k = 0; k < 6; k++) begin
      lat = $urandom_range(4, 1);
      ready_pct = 60;
      start_cmd($urandom_range((1 << AB) - 1), $urandom_range(30, 1), 16'($urandom));
      wait_done(400);
      drain_check($sformatf("rand%0d", k), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/nor_read_streamer.md
Name: nor_read_streamer

Overview:
- Upstream wishbone master for nor_bus: turns a (start address, word count) command into a pipelined burst of wishbone reads.
- Back-to-back same-page reads hit nor_bus page mode.
- Returned words are buffered in an internal FIFO and presented on a valid/ready stream to the readout/packetiser path.
- Credit-based issue guarantees the FIFO never overflows.

Parameters:
ADDRBITS, 26, NOR word address width (matches nor_bus)
DATABITS, 16, NOR data width (matches nor_bus)
LENBITS, 16, width of burst length field; max burst 2^LENBITS-1 words
FIFO_DEPTH, 16, output FIFO entries; power of two, >=2

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  reset, asynchronous, active-high
cmd_start_i  in  1  start pulse; sampled only in IDLE
cmd_addr_i  in  ADDRBITS  first word address
cmd_len_i  in  LENBITS  number of words to read
cmd_busy_o  out  1  high from accepted start until DONE inclusive
cmd_done_o  out  1  one-cycle completion pulse
cmd_err_o  out  1  burst aborted by wb_err_i; valid with cmd_done_o, held until next start
wb_cyc_o  out  1  wishbone cycle
wb_stb_o  out  1  wishbone strobe
wb_we_o  out  1  constant 0
wb_adr_o  out  ADDRBITS  read address
wb_dat_o  out  DATABITS  constant 0
wb_ack_i  in  1  ack, data valid
wb_dat_i  in  DATABITS  read data
wb_stall_i  in  1  slave stall
wb_err_i  in  1  slave error
m_valid_o  out  1  stream data valid
m_data_o  out  DATABITS  stream data
m_ready_i  in  1  stream consumer ready

Behaviour:
- Reset (async assert, sync deassert internally): state IDLE; cyc/stb/busy/done/err = 0; wb_adr_o = 0; FIFO empty; m_valid_o = 0; outstanding = 0.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - cyc = 0.
  - cmd_start_i with cmd_len_i != 0: latch addr/len, clear cmd_err_o, go to ISSUE next cycle.
  - cmd_start_i with cmd_len_i == 0: go to DONE directly with no bus activity.
  - Start while not IDLE: ignored.
- ISSUE:
  - cyc = 1.
  - stb = credit_ok, combinational; credit_ok = (outstanding + fifo_count) < FIFO_DEPTH.
  - Request accepted when stb && !wb_stall_i. On accept: wb_adr_o += 1 (wraps mod 2^ADDRBITS), remaining -= 1, outstanding += 1.
  - Accept with remaining == 1: go to DRAIN (stb low next cycle).
- DRAIN: cyc = 1, stb = 0; outstanding == 0 -> DONE.
- cyc must stay high from first issue to last ack; nor_bus flushes its queue on cyc low.
- DONE: cyc = 0, cmd_done_o = 1 for exactly one cycle, then IDLE. Earliest next start is sampled the cycle after DONE.
- Ack handling:
  - wb_ack_i with outstanding > 0: push wb_dat_i into FIFO, outstanding -= 1.
  - Ack in the same cycle as accept: outstanding unchanged.
  - Ack with outstanding == 0: ignored, no push.
- wb_err_i in ISSUE/DRAIN: next cycle go to DONE, cmd_err_o = 1, outstanding cleared, remaining discarded. Data already in FIFO is kept. An ack in the same cycle as err is still pushed.
- Stream:
  - m_valid_o = FIFO non-empty; m_data_o = FIFO head (first-word fall-through).
  - Pop on m_valid_o && m_ready_i.
  - Push and pop in the same cycle are allowed at any level.
  - Data order equals address order.
- FIFO is not flushed by DONE. A new command may start while the FIFO still holds data; credits account for it.
- Back-pressure: m_ready_i held low -> at most FIFO_DEPTH words requested, stb low, cyc held until ready resumes.
- Counters: outstanding and fifo_count are clog2(FIFO_DEPTH)+1 bits wide; no overflow by construction.

Optional Feature:
- Macro: NOR_STREAM_CHECKSUM_EN.
- Defined: adds output port sum_o [DATABITS]. sum_o is a running mod-2^DATABITS sum of every word pushed into the FIFO during the current command. It is cleared on accepted start and is stable from the cmd_done_o cycle until the next start. Reset value 0.
- Undefined: port and adder absent; all other behaviour identical.

Test Plan:
- Basic: start addr=0x000100 len=4, slave acks each word 2 cycles after accept with data=addr[15:0] -> stream 0x0100,0x0101,0x0102,0x0103; one cmd_done_o pulse; cmd_err_o=0.
- Back-pressure: FIFO_DEPTH=16, len=40, m_ready_i low -> exactly 16 accepts then stb low with cyc high. Raise ready -> all 40 words in order, no loss or duplication.
- Stall: wb_stall_i high for 5 cycles during ISSUE -> wb_adr_o holds, no accept counted, burst completes with the correct 8 addresses for len=8.
- Wrap/zero: addr=0x3FFFFFE len=3 -> addresses 0x3FFFFFE,0x3FFFFFF,0x0000000. Then len=0 -> done pulse with no cyc assertion.
- Error: len=10, wb_err_i on the 4th response after 3 acks -> cyc low next cycle, cmd_done_o=1, cmd_err_o=1, exactly 3 words in stream; next start works normally.
- Reset mid-burst: assert wb_rst_i during ISSUE with 3 outstanding -> cyc/stb/m_valid_o drop immediately (async); after release, start len=2 returns 2 correct words.
